// File: rtl/aes_key_expander_iter_if.sv
// Control, key and round-key read bundle of the
// iterative AES key expander.
interface aes_key_expander_iter_if #(
  parameter int MAX_KEY_BITS = 256
) ();
  logic                    start;
  logic [1:0]              key_size;
  logic [MAX_KEY_BITS-1:0] key_in;
  logic                    busy;
  logic                    done;
  logic                    err;
  logic                    keys_valid;
  logic [3:0]              num_rounds;
  logic [3:0]              rk_rd_idx;
  logic [127:0]            rk_rd_data;

  modport master (
    output start, key_size, key_in, rk_rd_idx,
    input  busy, done, err, keys_valid,
    input  num_rounds, rk_rd_data
  );

  modport slave (
    input  start, key_size, key_in, rk_rd_idx,
    output busy, done, err, keys_valid,
    output num_rounds, rk_rd_data
  );
endinterface

// File: rtl/aes_key_expander_iter.sv
// Iterative AES-128/192/256 key schedule: one word per
// clock into a word store, registered round-key read.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  function automatic logic [7:0] gmul(
    input logic [7:0] x,
    input logic [7:0] z
  );
    logic [7:0] p;
    logic [7:0] b;
    p = '0;
    b = x;
    for (int k = 0; k < 8; k++) begin
      if (z[k]) p = p ^ b;
      b = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  always_comb begin
    logic [7:0] r;
    logic [7:0] sq;
    // a^254 is the GF(2^8) inverse, mapping 0 to 0
    r  = 8'h01;
    sq = a;
    for (int k = 0; k < 8; k++) begin
      if (k != 0) r = gmul(r, sq);
      sq = gmul(sq, sq);
    end
    y = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]}
      ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]}
      ^ 8'h63;
  end
endmodule

module aes_key_expander_iter #(
  parameter int MAX_KEY_BITS = 256
) (
  input logic                    clk,
  input logic                    reset,
  aes_key_expander_iter_if.slave bus
);
  localparam int MAX_NK = MAX_KEY_BITS / 32;
  localparam int MAX_NR = 6 + MAX_NK;
  localparam int NW     = 4 * (MAX_NR + 1);

  typedef enum logic {IDLE, EXPAND} state_e;

  state_e        state_q, state_d;
  logic [31:0]   w_q [NW];
  logic [31:0]   w_d [NW];
  logic [5:0]    i_q, i_d;
  logic [2:0]    kmod_q, kmod_d;
  logic [3:0]    nk_q, nk_d;
  logic [7:0]    rcon_q, rcon_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          kv_q, kv_d;
  logic [3:0]    nr_q, nr_d;
  logic [127:0]  rd_q, rd_d;

  logic [31:0]   prev, back, sub_in, sub_out;
  logic [5:0]    base;
  logic [5:0]    total;
  logic [3:0]    nk_new;
  logic [8:0]    key_bits;
  logic          legal;

  assign prev   = w_q[i_q - 6'd1];
  assign back   = w_q[i_q - {2'b00, nk_q}];
  assign sub_in = (kmod_q == 3'd0) ?
                  {prev[23:0], prev[31:24]} : prev;

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .a (sub_in[8*b +: 8]),
      .y (sub_out[8*b +: 8])
    );
  end

  assign total    = {nk_q, 2'b00} + 6'd28;
  assign nk_new   = 4'd4 + {1'b0, bus.key_size, 1'b0};
  assign key_bits = 9'd128 + {1'b0, bus.key_size, 6'b0};
  assign legal    = (bus.key_size != 2'd3) &&
                    (int'(key_bits) <= MAX_KEY_BITS);
  assign base     = {bus.rk_rd_idx, 2'b00};

  always_comb begin
    logic [31:0] temp;
    state_d = state_q;
    w_d     = w_q;
    i_d     = i_q;
    kmod_d  = kmod_q;
    nk_d    = nk_q;
    rcon_d  = rcon_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    kv_d    = kv_q;
    nr_d    = nr_q;
    temp    = prev;
    unique case (state_q)
      IDLE: begin
        if (bus.start && legal) begin
          for (int k = 0; k < MAX_NK; k++) begin
            if (k < int'(nk_new))
              w_d[k] = bus.key_in[MAX_KEY_BITS-1-32*k -: 32];
          end
          nk_d    = nk_new;
          nr_d    = nk_new + 4'd6;
          i_d     = {2'b00, nk_new};
          kmod_d  = 3'd0;
          rcon_d  = 8'h01;
          busy_d  = 1'b1;
          kv_d    = 1'b0;
          state_d = EXPAND;
        end else if (bus.start) begin
          err_d = 1'b1;
        end
      end
      EXPAND: begin
        if (kmod_q == 3'd0) begin
          temp   = sub_out ^ {rcon_q, 24'h0};
          rcon_d = {rcon_q[6:0], 1'b0} ^
                   (rcon_q[7] ? 8'h1b : 8'h00);
        end else if (nk_q == 4'd8 && kmod_q == 3'd4) begin
          temp = sub_out;
        end
        w_d[i_q] = back ^ temp;
        i_d      = i_q + 6'd1;
        kmod_d   = ({1'b0, kmod_q} == nk_q - 4'd1) ?
                   3'd0 : kmod_q + 3'd1;
        if (i_q == total - 6'd1) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          kv_d    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_d = '0;
    if (bus.rk_rd_idx <= nr_q)
      rd_d = {w_q[base], w_q[base + 6'd1],
              w_q[base + 6'd2], w_q[base + 6'd3]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      w_q     <= '{default: '0};
      i_q     <= '0;
      kmod_q  <= '0;
      nk_q    <= '0;
      rcon_q  <= 8'h01;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      kv_q    <= 1'b0;
      nr_q    <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      i_q     <= i_d;
      kmod_q  <= kmod_d;
      nk_q    <= nk_d;
      rcon_q  <= rcon_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      kv_q    <= kv_d;
      nr_q    <= nr_d;
      rd_q    <= rd_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.keys_valid = kv_q;
  assign bus.num_rounds = nr_q;
  assign bus.rk_rd_data = rd_q;
endmodule

// File: doc/aes_key_expander_iter.md
Name: aes_key_expander_iter

Overview:
Iterative, multi-key-length AES key schedule (FIPS-197) supporting 128/192/256-bit keys, selected per run. It generates one 32-bit schedule word per clock using one 4-byte SubWord path, and stores the full schedule in an internal word register file. It exposes a registered random-access round-key read port. It sits between key load control and an iterative/pipelined cipher core, replacing the fixed ten-stage AES-128-only expansion chain with a smaller-area engine.

Parameters:
MAX_KEY_BITS, 256, largest supported key (128, 192 or 256); sizes key_in and word store (4*(MAX_NR+1) words, MAX_NR=6+MAX_KEY_BITS/32)

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high
start  input  1  request expansion; sampled only when busy=0
key_size  input  2  0=AES-128, 1=AES-192, 2=AES-256, 3=illegal
key_in  input  MAX_KEY_BITS  cipher key, left-aligned (word 0 at MSBs); unused LSBs ignored
busy  output  1  expansion in progress
done  output  1  one-cycle pulse after final word written
err  output  1  one-cycle pulse on rejected start
keys_valid  output  1  level: full schedule for current key available
num_rounds  output  4  Nr of latched key: 10/12/14
rk_rd_idx  input  4  round-key index 0..Nr
rk_rd_data  output  128  round key {w[4r],w[4r+1],w[4r+2],w[4r+3]}, w[4r] at MSBs

Behaviour:
- Reset (synchronous, active-high; overrides start): state IDLE; busy, done, err, keys_valid = 0; num_rounds = 0; rk_rd_data = 0; all stored words = 0; rcon = 8'h01.
- Terms: Nk = 4/6/8; Nr = Nk+6; TOTAL = 4*(Nr+1) = 44/52/60.
- FSM states: IDLE, EXPAND.
- IDLE accept:
  - Accept when start=1 and key_size legal and key bits <= MAX_KEY_BITS.
  - Same edge: w[0..Nk-1] <- key_in words; latch Nk and num_rounds; i <- Nk; rcon <- 01; busy <- 1; keys_valid <- 0; go to EXPAND.
- IDLE reject: start=1 with key_size=3 or key too long for MAX_KEY_BITS → err=1 for one cycle; no other state change, including keys_valid.
- EXPAND, one word per edge:
  - temp = w[i-1].
  - If i mod Nk == 0: temp = SubWord(RotWord(temp)) ^ {rcon,24'h0}; rcon <- xtime(rcon), i.e. shift left, XOR 8'h1b if bit 7 was set.
  - Else if Nk==8 and i mod 8 == 4: temp = SubWord(temp).
  - w[i] <- w[i-Nk] ^ temp; i <- i+1.
  - Track i mod Nk with a wrapping counter; no divider.
- Completion: on the edge writing w[TOTAL-1], go to IDLE; busy <- 0; done <- 1 for one cycle; keys_valid <- 1.
- Latency: done is high in the cycle starting TOTAL-Nk edges after the accept edge, i.e. 40/46/52 cycles.
- start while busy=1: ignored, no err, no effect on the run in progress.
- Read port: rk_rd_data <- words 4r..4r+3 on every edge, one-cycle latency.
  - rk_rd_idx > num_rounds: rk_rd_data <- 0.
  - Reads during EXPAND return current store contents; they are meaningful only when keys_valid=1.
- Back-to-back: start may be accepted in the cycle done is high (busy already 0). keys_valid then drops on that accept edge.
- Reset mid-EXPAND: immediate return to reset values; the partial schedule is discarded.
- SubWord uses four instances of the team's AES S-box.

Test Plan:
- AES-128 key 2b7e1516_28aed2a6_abf71588_09cf4f3c, start → done exactly 40 cycles after accept; num_rounds=10; rk_rd_idx=10 → next cycle rk_rd_data = d014f9a8_c9ee2589_e13f0cc8_b6630ca6; idx=0 returns the key.
- AES-192 key 8e73b0f7_da0e6452_c810f32b_809079e5_62f8ead2_522c6b7b → done after 46 cycles; num_rounds=12; idx=12 → e98ba06f_448c773c_8ecc7204_01002202; idx=13 → 0.
- AES-256 key 603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4 → done after 52 cycles; num_rounds=14; idx=14 → fe4890d1_e6188d0b_046df344_706c631e.
- key_size=3, start → err for one cycle, busy stays 0, prior keys_valid=1 and stored keys unchanged. Separately, start pulsed mid-run → ignored; completion timing and results unchanged.
- Reset asserted 20 cycles into an AES-256 run → next cycle busy=0, keys_valid=0, rk_rd_data=0 one cycle later. A fresh AES-128 run then completes in 40 cycles with the correct round-10 key.
- start asserted in the done cycle with a new key → accepted, keys_valid drops, and the second schedule is correct.
